// File: rtl/erroneous_gate_pkg.sv
// Shared types and helpers for the fault-injecting gate array.
package erroneous_gate_pkg;

   typedef enum logic [1:0] {
      GATE_NAND = 2'b00,
      GATE_NOR  = 2'b01,
      GATE_AND  = 2'b10,
      GATE_XOR  = 2'b11
   } gate_e;

   typedef enum logic {
      FAULT_TRANSIENT = 1'b0,
      FAULT_STUCK     = 1'b1
   } fault_mode_e;

   typedef enum logic {
      LANE_OK    = 1'b0,
      LANE_STUCK = 1'b1
   } lane_state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SEED_MUL  = 16'h9E37;

   // Per-lane seed: base ^ (SEED_MUL * (idx+1)), never zero.
   function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned idx);
      logic [31:0] prod;
      logic [15:0] s;
      prod = 32'(SEED_MUL) * 32'(idx + 1);
      s    = base ^ prod[15:0];
      if (s == '0) s = 16'h0001;
      return s;
   endfunction

   function automatic logic gate_eval(input gate_e g, input logic a, input logic b);
      logic r;
      case (g)
         GATE_NAND: r = ~(a & b);
         GATE_NOR:  r = ~(a | b);
         GATE_AND:  r = a & b;
         default:   r = a ^ b;
      endcase
      return r;
   endfunction

   // Galois right-shift step.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/erroneous_gate_lane.sv
// One fault-injecting gate lane: LFSR, OK/STUCK FSM, stuck timer,
// saturating fault counter and registered outputs.
module erroneous_gate_lane
   import erroneous_gate_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned STUCK_CYCLES = 4,
   parameter logic [15:0] LANE_SEED    = 16'h0001
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  gate_e            gate_sel_i,
   input  fault_mode_e      fault_mode_i,
   input  logic [15:0]      error_thresh_i,
   input  logic             clr_cnt_i,
   input  logic             x_i,
   input  logic             y_i,
   output logic             z_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int unsigned SC_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;

   lane_state_e      r_state;
   logic [15:0]      r_lfsr;
   logic [SC_W-1:0]  r_stuck_cnt;
   logic             r_stuck_val;
   logic             r_z;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   lane_state_e      w_state_nxt;
   logic [SC_W-1:0]  w_stuck_cnt_nxt;
   logic             w_stuck_val_nxt;
   logic             w_z_nxt;
   logic             w_err_nxt;
   logic             w_inc;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_ideal;
   logic             w_fault;

   assign w_ideal = gate_eval(gate_sel_i, x_i, y_i);
   assign w_fault = (r_lfsr <= error_thresh_i);

   // Next-state and next-output logic for the OK/STUCK lane FSM.
   // The episode ends on the transition that drains the timer to zero,
   // so the faulty value is shown on exactly STUCK_CYCLES enabled outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_stuck_cnt_nxt = r_stuck_cnt;
      w_stuck_val_nxt = r_stuck_val;
      w_z_nxt         = w_ideal;
      w_err_nxt       = 1'b0;
      w_inc           = 1'b0;
      unique case (r_state)
         LANE_OK: begin
            if (w_fault) begin
               w_z_nxt   = ~w_ideal;
               w_err_nxt = 1'b1;
               w_inc     = 1'b1;
               if (fault_mode_i == FAULT_STUCK) begin
                  w_stuck_val_nxt = ~w_ideal;
                  w_stuck_cnt_nxt = SC_W'(STUCK_CYCLES - 1);
                  w_state_nxt     = (STUCK_CYCLES > 1) ? LANE_STUCK : LANE_OK;
               end
            end
         end
         LANE_STUCK: begin
            w_z_nxt   = r_stuck_val;
            w_err_nxt = r_stuck_val ^ w_ideal;
            if (r_stuck_cnt != '0) w_stuck_cnt_nxt = r_stuck_cnt - 1'b1;
            if (r_stuck_cnt <= SC_W'(1)) w_state_nxt = LANE_OK;
         end
         default: w_state_nxt = LANE_OK;
      endcase
      w_cnt_nxt = r_cnt;
      if (w_inc && (r_cnt != '1)) w_cnt_nxt = r_cnt + 1'b1;
   end

   // Lane state registers; everything holds while disabled except the counter clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= LANE_OK;
         r_lfsr      <= LANE_SEED;
         r_stuck_cnt <= '0;
         r_stuck_val <= 1'b0;
         r_z         <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         if (en_i) begin
            r_state     <= w_state_nxt;
            r_lfsr      <= lfsr_next(r_lfsr);
            r_stuck_cnt <= w_stuck_cnt_nxt;
            r_stuck_val <= w_stuck_val_nxt;
            r_z         <= w_z_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
         end
         if (clr_cnt_i) r_cnt <= '0;
      end
   end

   assign z_o       = r_z;
   assign err_o     = r_err;
   assign err_cnt_o = r_cnt;

endmodule

// File: rtl/erroneous_gate_array.sv
// Multi-channel fault-injecting gate: CHANNELS independent lanes with
// shared gate select, fault mode and error threshold.
module erroneous_gate_array
   import erroneous_gate_pkg::*;
#(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned STUCK_CYCLES = 4,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en_i,
   input  logic [1:0]                gate_sel_i,
   input  logic                      fault_mode_i,
   input  logic [15:0]               error_thresh_i,
   input  logic                      clr_cnt_i,
   input  logic [CHANNELS-1:0]       x_i,
   input  logic [CHANNELS-1:0]       y_i,
   output logic [CHANNELS-1:0]       z_o,
   output logic [CHANNELS-1:0]       err_o,
   output logic [CHANNELS*CNT_W-1:0] err_cnt_o
);

   gate_e       w_gate;
   fault_mode_e w_mode;

   assign w_gate = gate_e'(gate_sel_i);
   assign w_mode = fault_mode_e'(fault_mode_i);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      erroneous_gate_lane #(
         .CNT_W        (CNT_W),
         .STUCK_CYCLES (STUCK_CYCLES),
         .LANE_SEED    (lane_seed(SEED, g))
      ) u_lane (
         .clk            (clk),
         .reset          (reset),
         .en_i           (en_i),
         .gate_sel_i     (w_gate),
         .fault_mode_i   (w_mode),
         .error_thresh_i (error_thresh_i),
         .clr_cnt_i      (clr_cnt_i),
         .x_i            (x_i[g]),
         .y_i            (y_i[g]),
         .z_o            (z_o[g]),
         .err_o          (err_o[g]),
         .err_cnt_o      (err_cnt_o[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_erroneous_gate_array.sv
// Directed self-checking bench for erroneous_gate_array (4 lanes, 4-bit counters, 3-cycle stuck).
module tb_erroneous_gate_array;

   localparam int NCH = 4;
   localparam int CW  = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           en_i = 1'b0;
   logic [1:0]     gate_sel_i = 2'b00;
   logic           fault_mode_i = 1'b0;
   logic [15:0]    error_thresh_i = 16'h0000;
   logic           clr_cnt_i = 1'b0;
   logic [NCH-1:0] x_i = '0;
   logic [NCH-1:0] y_i = '0;
   logic [NCH-1:0] z_o;
   logic [NCH-1:0] err_o;
   logic [NCH*CW-1:0] err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [NCH-1:0] first20 [20];

   erroneous_gate_array #(
      .CHANNELS     (NCH),
      .CNT_W        (CW),
      .STUCK_CYCLES (3),
      .SEED         (16'hACE1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en_i           (en_i),
      .gate_sel_i     (gate_sel_i),
      .fault_mode_i   (fault_mode_i),
      .error_thresh_i (error_thresh_i),
      .clr_cnt_i      (clr_cnt_i),
      .x_i            (x_i),
      .y_i            (y_i),
      .z_o            (z_o),
      .err_o          (err_o),
      .err_cnt_o      (err_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [NCH-1:0] ideal_f(input logic [1:0] g, input logic [NCH-1:0] a, input logic [NCH-1:0] b);
      case (g)
         2'b00:   return ~(a & b);
         2'b01:   return ~(a | b);
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [15:0] seed_of(input int i);
      logic [31:0] p;
      logic [15:0] s;
      p = 32'h0000_9E37 * (i + 1);
      s = 16'hACE1 ^ p[15:0];
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   function automatic logic [15:0] step(input logic [15:0] s);
      logic [15:0] t;
      t = {1'b0, s[15:1]};
      if (s[0]) t = t ^ 16'hB400;
      return t;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en_i = 1'b0;
      clr_cnt_i = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      en_i = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (z_o !== 4'h0) begin n_errors++; $display("FAIL reset_z got=%h exp=0", z_o); end
      n_checks++;
      if (err_o !== 4'h0) begin n_errors++; $display("FAIL reset_err got=%h exp=0", err_o); end
      n_checks++;
      if (err_cnt_o !== 16'h0000) begin n_errors++; $display("FAIL reset_cnt got=%h exp=0000", err_cnt_o); end
   endtask

   task automatic test_ideal();
      logic [NCH-1:0] exp_z;
      logic [7:0] c;
      do_reset();
      error_thresh_i = 16'h0000;
      fault_mode_i = 1'b0;
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 50; k++) begin
            c = 8'(k);
            gate_sel_i = 2'(g);
            x_i = c[3:0];
            y_i = {c[0], c[3:1]};
            exp_z = ideal_f(2'(g), c[3:0], {c[0], c[3:1]});
            @(posedge clk); #1;
            n_checks++;
            if (z_o !== exp_z) begin n_errors++; $display("FAIL ideal_z g=%0d k=%0d got=%b exp=%b", g, k, z_o, exp_z); end
            n_checks++;
            if (err_o !== 4'h0) begin n_errors++; $display("FAIL ideal_err g=%0d k=%0d got=%b exp=0000", g, k, err_o); end
         end
      end
      n_checks++;
      if (err_cnt_o !== 16'h0000) begin n_errors++; $display("FAIL ideal_cnt got=%h exp=0000", err_cnt_o); end
   endtask

   task automatic test_transient();
      logic [CW-1:0] exp_c;
      do_reset();
      error_thresh_i = 16'hFFFF;
      fault_mode_i = 1'b0;
      gate_sel_i = 2'b00;
      x_i = 4'b1010;
      y_i = 4'b1100;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         exp_c = (k >= 15) ? 4'd15 : 4'(k);
         n_checks++;
         if (z_o !== 4'b1000) begin n_errors++; $display("FAIL trans_z k=%0d got=%b exp=1000", k, z_o); end
         n_checks++;
         if (err_o !== 4'hF) begin n_errors++; $display("FAIL trans_err k=%0d got=%b exp=1111", k, err_o); end
         n_checks++;
         if (err_cnt_o !== {4{exp_c}}) begin n_errors++; $display("FAIL trans_cnt k=%0d got=%h exp=%h", k, err_cnt_o, {4{exp_c}}); end
      end
      clr_cnt_i = 1'b1;
      @(posedge clk); #1;
      clr_cnt_i = 1'b0;
      n_checks++;
      if (err_cnt_o !== 16'h0000) begin n_errors++; $display("FAIL trans_clr got=%h exp=0000", err_cnt_o); end
      @(posedge clk); #1;
      n_checks++;
      if (err_cnt_o !== 16'h1111) begin n_errors++; $display("FAIL trans_after_clr got=%h exp=1111", err_cnt_o); end
   endtask

   task automatic test_stuck();
      logic exp_z [9];
      logic exp_e [9];
      int   exp_c [9];
      exp_z = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_e = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_c = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
      do_reset();
      error_thresh_i = 16'hFFFF;
      fault_mode_i = 1'b1;
      gate_sel_i = 2'b00;
      for (int k = 0; k < 9; k++) begin
         x_i = (k % 2 == 0) ? 4'hF : 4'h0;
         y_i = x_i;
         @(posedge clk); #1;
         n_checks++;
         if (z_o !== {4{exp_z[k]}}) begin n_errors++; $display("FAIL stuck_z k=%0d got=%b exp=%b", k, z_o, {4{exp_z[k]}}); end
         n_checks++;
         if (err_o !== {4{exp_e[k]}}) begin n_errors++; $display("FAIL stuck_err k=%0d got=%b exp=%b", k, err_o, {4{exp_e[k]}}); end
         n_checks++;
         if (err_cnt_o !== {4{4'(exp_c[k])}}) begin n_errors++; $display("FAIL stuck_cnt k=%0d got=%h exp=%h", k, err_cnt_o, {4{4'(exp_c[k])}}); end
      end
   endtask

   task automatic test_freeze();
      do_reset();
      error_thresh_i = 16'hFFFF;
      fault_mode_i = 1'b1;
      gate_sel_i = 2'b00;
      x_i = 4'hF; y_i = 4'hF;
      @(posedge clk); #1;
      x_i = 4'h0; y_i = 4'h0;
      @(posedge clk); #1;
      n_checks++;
      if (z_o !== 4'hF || err_o !== 4'h0) begin n_errors++; $display("FAIL frz_pre got z=%b e=%b exp z=1111 e=0000", z_o, err_o); end
      en_i = 1'b0;
      x_i = 4'hF; y_i = 4'hF;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (z_o !== 4'hF || err_o !== 4'h0 || err_cnt_o !== 16'h1111) begin
            n_errors++; $display("FAIL frz_hold k=%0d got z=%b e=%b c=%h exp z=1111 e=0000 c=1111", k, z_o, err_o, err_cnt_o);
         end
      end
      en_i = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (z_o !== 4'hF || err_o !== 4'hF || err_cnt_o !== 16'h1111) begin
         n_errors++; $display("FAIL frz_resume got z=%b e=%b c=%h exp z=1111 e=1111 c=1111", z_o, err_o, err_cnt_o);
      end
      x_i = 4'h0; y_i = 4'h0;
      @(posedge clk); #1;
      n_checks++;
      if (z_o !== 4'h0 || err_o !== 4'hF || err_cnt_o !== 16'h2222) begin
         n_errors++; $display("FAIL frz_refault got z=%b e=%b c=%h exp z=0000 e=1111 c=2222", z_o, err_o, err_cnt_o);
      end
      en_i = 1'b0;
      clr_cnt_i = 1'b1;
      @(posedge clk); #1;
      clr_cnt_i = 1'b0;
      n_checks++;
      if (z_o !== 4'h0 || err_o !== 4'hF || err_cnt_o !== 16'h0000) begin
         n_errors++; $display("FAIL frz_clr got z=%b e=%b c=%h exp z=0000 e=1111 c=0000", z_o, err_o, err_cnt_o);
      end
      en_i = 1'b1;
   endtask

   task automatic test_lfsr();
      logic [15:0]    m [NCH];
      logic [NCH-1:0] e;
      int             diff01, diff23;
      diff01 = 0;
      diff23 = 0;
      do_reset();
      error_thresh_i = 16'h8000;
      fault_mode_i = 1'b0;
      gate_sel_i = 2'b00;
      x_i = 4'h0; y_i = 4'h0;
      for (int i = 0; i < NCH; i++) m[i] = seed_of(i);
      for (int k = 0; k < 1000; k++) begin
         for (int i = 0; i < NCH; i++) e[i] = (m[i] <= 16'h8000);
         @(posedge clk); #1;
         n_checks++;
         if (err_o !== e || z_o !== ~e) begin
            n_errors++; $display("FAIL lfsr k=%0d got e=%b z=%b exp e=%b z=%b", k, err_o, z_o, e, ~e);
         end
         if (k < 20) first20[k] = e;
         if (e[0] != e[1]) diff01++;
         if (e[2] != e[3]) diff23++;
         for (int i = 0; i < NCH; i++) m[i] = step(m[i]);
      end
      n_checks++;
      if (diff01 == 0 || diff23 == 0) begin n_errors++; $display("FAIL lfsr_lanes_differ got d01=%0d d23=%0d exp both >0", diff01, diff23); end
   endtask

   task automatic test_async_reset();
      do_reset();
      error_thresh_i = 16'hFFFF;
      fault_mode_i = 1'b1;
      gate_sel_i = 2'b00;
      x_i = 4'hF; y_i = 4'hF;
      @(posedge clk); #1;
      n_checks++;
      if (z_o !== 4'hF || err_cnt_o !== 16'h1111) begin n_errors++; $display("FAIL arst_pre got z=%b c=%h exp z=1111 c=1111", z_o, err_cnt_o); end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (z_o !== 4'h0 || err_o !== 4'h0 || err_cnt_o !== 16'h0000) begin
         n_errors++; $display("FAIL arst_now got z=%b e=%b c=%h exp all 0", z_o, err_o, err_cnt_o);
      end
      error_thresh_i = 16'h8000;
      fault_mode_i = 1'b0;
      x_i = 4'h0; y_i = 4'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (err_o !== first20[k]) begin n_errors++; $display("FAIL arst_replay k=%0d got=%b exp=%b", k, err_o, first20[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_transient();
      test_stuck();
      test_freeze();
      test_lfsr();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
